// File: rtl/intr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : intr_pkg
// Description : Shared constants for the interrupt handshake: bus codes,
//               responder state encoding and a bus-word helper. Used by both
//               the interrupt controller and the CPU-side responder.
// Revision    : 1.0 - initial release
// ============================================================================
package intr_pkg;

    localparam int INTR_ID_W = 3;

    // Upper five bits of the interrupt bus identify who is talking
    localparam logic [4:0] INTR_CODE_ID   = 5'b01011;
    localparam logic [4:0] INTR_CODE_DONE = 5'b10100;

    // Responder state encoding
    typedef logic [2:0] resp_state_t;
    localparam resp_state_t S_IDLE    = 3'd0;
    localparam resp_state_t S_ACK1    = 3'd1;
    localparam resp_state_t S_WAIT_ID = 3'd2;
    localparam resp_state_t S_ACK2    = 3'd3;
    localparam resp_state_t S_SERVICE = 3'd4;
    localparam resp_state_t S_TURN    = 3'd5;
    localparam resp_state_t S_DONE    = 3'd6;

    // Builds the word the responder puts on the bus to close a handshake
    function automatic logic [7:0] intr_done_word(input logic [INTR_ID_W-1:0] id);
        return {INTR_CODE_DONE, id};
    endfunction

endpackage
`default_nettype wire

// File: rtl/interrupt_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : interrupt_responder_if
// Description : Handshake signals between interrupt controller, responder
//               and CPU core. master = responder side, slave = environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface interrupt_responder_if;

    logic       intr;
    logic       intr_ack_n;
    logic       bus_oe;
    logic       intr_enable;
    logic       isr_start;
    logic [2:0] isr_id;
    logic       isr_done;
    logic       busy;
    logic       intr_err;

    modport master (
        input  intr, intr_enable, isr_done,
        output intr_ack_n, bus_oe, isr_start, isr_id, busy, intr_err
    );

    modport slave (
        output intr, intr_enable, isr_done,
        input  intr_ack_n, bus_oe, isr_start, isr_id, busy, intr_err
    );

endinterface
`default_nettype wire

// File: rtl/intr_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : intr_watchdog
// Description : Down-counter watchdog. clr reloads it, en counts it down,
//               expired is high once LOAD enabled cycles have elapsed since
//               the last clear (i.e. on the LOAD-th enabled cycle).
// Revision    : 1.0 - initial release
// ============================================================================
module intr_watchdog #(
    parameter int LOAD = 16
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic clr,
    input  wire logic en,
    output logic      expired
);

    localparam int              CNT_W      = (LOAD > 1) ? $clog2(LOAD) : 1;
    localparam logic [CNT_W-1:0] c_LOAD_VAL = CNT_W'(LOAD - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Reload on clear, otherwise count down and park at zero
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = c_LOAD_VAL;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= c_LOAD_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/interrupt_responder.sv
`default_nettype none
// ============================================================================
// Module      : interrupt_responder
// Description : CPU-side end of the interrupt handshake. Acknowledges the
//               controller's request, captures the source ID from the shared
//               bus, releases it, starts the ISR and returns the done code.
//               Optional ID watchdog enabled by INTR_RESP_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module interrupt_responder
    import intr_pkg::*;
#(
    parameter int ID_TIMEOUT = 16
) (
    input  wire logic           clk,
    input  wire logic           reset,
    interrupt_responder_if.master ifc,
    inout  wire logic [7:0]     intr_bus
);

    resp_state_t           state_q, state_d;
    logic                  ack_n_q, ack_n_d;
    logic                  bus_oe_q, bus_oe_d;
    logic [7:0]            bus_data_q, bus_data_d;
    logic                  isr_start_q, isr_start_d;
    logic [INTR_ID_W-1:0]  isr_id_q, isr_id_d;
    logic                  busy_q, busy_d;
    logic                  w_id_valid;
    logic                  w_timeout;

    assign w_id_valid = (intr_bus[7:3] == INTR_CODE_ID);

`ifdef INTR_RESP_TIMEOUT_EN
    logic intr_err_q, intr_err_d;

    // Watchdog only runs while waiting for the controller's ID
    intr_watchdog #(
        .LOAD (ID_TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clr     (state_q != S_WAIT_ID),
        .en      (state_q == S_WAIT_ID),
        .expired (w_timeout)
    );

    // Sticky error: set when the watchdog aborts an ID wait
    always_comb begin
        intr_err_d = intr_err_q;
        if ((state_q == S_WAIT_ID) && !w_id_valid && w_timeout) begin
            intr_err_d = 1'b1;
        end
    end

    // Error flag register, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            intr_err_q <= 1'b0;
        end else begin
            intr_err_q <= intr_err_d;
        end
    end

    assign ifc.intr_err = intr_err_q;
`else
    logic w_unused_timeout;

    assign w_timeout        = 1'b0;
    assign w_unused_timeout = (ID_TIMEOUT != 0);
    assign ifc.intr_err     = 1'b0;
`endif

    // State and registered outputs; reset also drops ack and releases the bus
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ack_n_q     <= 1'b1;
            bus_oe_q    <= 1'b0;
            bus_data_q  <= '0;
            isr_start_q <= 1'b0;
            isr_id_q    <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ack_n_q     <= ack_n_d;
            bus_oe_q    <= bus_oe_d;
            bus_data_q  <= bus_data_d;
            isr_start_q <= isr_start_d;
            isr_id_q    <= isr_id_d;
            busy_q      <= busy_d;
        end
    end

    // Handshake sequencing; a falling intr mid-handshake is deliberately ignored
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (ifc.intr && ifc.intr_enable) state_d = S_ACK1;
            S_ACK1:    state_d = S_WAIT_ID;
            S_WAIT_ID: begin
                if (w_id_valid) begin
                    state_d = S_ACK2;
                end else if (w_timeout) begin
                    state_d = S_IDLE;
                end
            end
            S_ACK2:    state_d = S_SERVICE;
            S_SERVICE: if (ifc.isr_done) state_d = S_TURN;
            S_TURN:    state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Output values for the coming cycle, derived from the next state so
    // every port comes straight from a flop
    always_comb begin
        ack_n_d     = !((state_d == S_ACK1) || (state_d == S_ACK2) || (state_d == S_DONE));
        bus_oe_d    = (state_d == S_DONE);
        bus_data_d  = bus_oe_d ? intr_done_word(isr_id_q) : 8'h00;
        isr_start_d = (state_d == S_SERVICE) && (state_q != S_SERVICE);
        busy_d      = (state_d != S_IDLE);
        isr_id_d    = isr_id_q;
        if ((state_q == S_WAIT_ID) && w_id_valid) begin
            isr_id_d = intr_bus[2:0];
        end
    end

    assign intr_bus       = bus_oe_q ? bus_data_q : 8'hzz;
    assign ifc.intr_ack_n = ack_n_q;
    assign ifc.bus_oe     = bus_oe_q;
    assign ifc.isr_start  = isr_start_q;
    assign ifc.isr_id     = isr_id_q;
    assign ifc.busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_interrupt_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_interrupt_responder
// Description : Testbench for interrupt_responder with an interrupt
//               controller / CPU model. Timeout scenario is built only when
//               INTR_RESP_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_interrupt_responder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    wire  [7:0] intr_bus;
    logic       ctl_oe = 1'b0;
    logic [7:0] ctl_data = 8'h00;

    interrupt_responder_if ifc ();

    interrupt_responder #(
        .ID_TIMEOUT (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ifc      (ifc),
        .intr_bus (intr_bus)
    );

    assign intr_bus = ctl_oe ? ctl_data : 8'hzz;

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Request table written by the stimulus, consumed by the controller model
    int id_arr  [256];
    int dly_arr [256];
    int wr_ptr    = 0;
    bit hold_done = 1'b0;
    bit mute      = 1'b0;

    // Controller/CPU model state (owned by the monitor process)
    int rd_ptr   = 0;
    int phase    = 0;
    int cyc      = 0;
    int req_cyc  = -1;
    int ack1_cyc = 0;
    int done_cyc = 0;
    int svc      = 0;
    int cur_id   = 0;
    int cur_dly  = 0;
    int done_cnt = 0;
    int tout_cnt = 0;
    bit ack_low_prev = 1'b0;

    initial begin
        ifc.intr     = 1'b0;
        ifc.isr_done = 1'b0;
    end

    // Controller + CPU model and protocol checker, evaluated mid-cycle
    always @(negedge clk) begin
        cyc++;
        check_val("ack_twice", int'(ack_low_prev && !ifc.intr_ack_n), 0);
        check_val("bus_overlap", int'(ctl_oe && ifc.bus_oe), 0);
        ack_low_prev = !ifc.intr_ack_n;
        if (reset) begin
            phase        = 0;
            ctl_oe       = 1'b0;
            ifc.intr     = 1'b0;
            ifc.isr_done = 1'b0;
            req_cyc      = -1;
        end else begin
            case (phase)
                0: begin
                    ifc.isr_done = hold_done;
                    if (!ifc.intr_ack_n) begin
                        check_val("ack_latency", cyc - req_cyc, 1);
                        if (rd_ptr < wr_ptr) begin
                            cur_id  = id_arr[rd_ptr];
                            cur_dly = dly_arr[rd_ptr];
                            rd_ptr++;
                        end
                        phase    = 1;
                        ack1_cyc = cyc;
                        ifc.intr = 1'b0;
                        req_cyc  = -1;
                        if (!mute) begin
                            ctl_oe   = 1'b1;
                            ctl_data = {5'b01011, 3'(cur_id)};
                        end
                    end else begin
                        check_val("idle_busy", int'(ifc.busy), 0);
                        ifc.intr = (rd_ptr < wr_ptr);
                        if (!ifc.intr_enable) req_cyc = -1;
                        else if (ifc.intr && req_cyc < 0) req_cyc = cyc;
                    end
                end
                1: begin
                    ifc.isr_done = hold_done;
                    if (mute) begin
                        if (cyc - ack1_cyc == 4) begin
                            check_val("err_early", int'(ifc.intr_err), int'(tout_cnt > 0));
                        end else if (cyc - ack1_cyc == 5) begin
                            check_val("tout_err", int'(ifc.intr_err), 1);
                            check_val("tout_busy", int'(ifc.busy), 0);
                            check_val("tout_bus_oe", int'(ifc.bus_oe), 0);
                            check_val("tout_ack_n", int'(ifc.intr_ack_n), 1);
                            tout_cnt++;
                            phase = 0;
                        end
                    end else if (!ifc.intr_ack_n) begin
                        check_val("ack2_latency", cyc - ack1_cyc, 2);
                        ctl_oe = 1'b0;
                        phase  = 2;
                    end else if (cyc - ack1_cyc >= 3) begin
                        check_val("ack2_missing", 0, 1);
                        ctl_oe = 1'b0;
                        phase  = 0;
                    end
                end
                2, 3: begin
                    if (phase == 2) begin
                        check_val("isr_start_at_e3", int'(ifc.isr_start), 1);
                        check_val("isr_id", int'(ifc.isr_id), cur_id);
                        phase = 3;
                        svc   = 0;
                    end else begin
                        check_val("isr_start_single", int'(ifc.isr_start), 0);
                    end
                    check_val("svc_busy", int'(ifc.busy), 1);
                    check_val("svc_ack_n", int'(ifc.intr_ack_n), 1);
                    ifc.isr_done = hold_done || (svc == cur_dly);
                    if (ifc.isr_done) begin
                        done_cyc = cyc;
                        phase    = 4;
                    end else if (svc > cur_dly + 50) begin
                        check_val("svc_hang", svc, cur_dly);
                        phase = 0;
                    end
                    svc++;
                end
                default: begin
                    ifc.isr_done = hold_done;
                    if (!ifc.intr_ack_n) begin
                        check_val("done_latency", cyc - done_cyc, 2);
                        check_val("done_bus_oe", int'(ifc.bus_oe), 1);
                        check_val("done_code", int'(intr_bus), int'({5'b10100, 3'(cur_id)}));
                        done_cnt++;
                        phase = 0;
                    end else if (cyc - done_cyc == 1) begin
                        check_val("turn_bus_oe", int'(ifc.bus_oe), 0);
                    end else begin
                        check_val("done_missing", cyc - done_cyc, 2);
                        phase = 0;
                    end
                end
            endcase
        end
    end

    task automatic push_req(input int id, input int dly);
        id_arr[wr_ptr]  = id;
        dly_arr[wr_ptr] = dly;
        wr_ptr++;
    endtask

    task automatic wait_done(input int n);
        int target;
        target = done_cnt + n;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (done_cnt >= target) break;
        end
        check_val("txn_complete", done_cnt, target);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_ack_n"}, int'(ifc.intr_ack_n), 1);
        check_val({tag, "_bus_oe"}, int'(ifc.bus_oe), 0);
        check_val({tag, "_isr_id"}, int'(ifc.isr_id), 0);
        check_val({tag, "_busy"}, int'(ifc.busy), 0);
    endtask

    // Global guard so the run always ends
    initial begin
        #400000;
        $display("FAIL global_timeout: observed running, expected finished");
        $fatal(1, "simulation time limit");
    end

    // Stimulus
    initial begin
        bit seen;
        ifc.intr_enable = 1'b1;
        reset           = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        check_val("rst_isr_start", int'(ifc.isr_start), 0);
        check_val("rst_intr_err", int'(ifc.intr_err), 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Source 5, isr_done held high
        hold_done = 1'b1;
        push_req(5, 0);
        wait_done(1);
        hold_done = 1'b0;

        // Source 2, isr_done after 20 service cycles
        push_req(2, 20);
        wait_done(1);

        // Request pending while interrupts are disabled
        ifc.intr_enable = 1'b0;
        push_req(3, 1);
        repeat (30) @(posedge clk);
        #1;
        check_val("disabled_no_ack", rd_ptr, wr_ptr - 1);
        ifc.intr_enable = 1'b1;
        wait_done(1);

        // Back-to-back sources 1 and 6
        push_req(1, 0);
        push_req(6, 2);
        wait_done(2);

        // Randomized transactions
        for (int i = 0; i < 12; i++) begin
            push_req(int'($urandom_range(0, 7)), int'($urandom_range(0, 6)));
            if ($urandom_range(0, 1) == 1) begin
                wait_done(1);
            end
        end
        wait_done(wr_ptr - rd_ptr + ((phase != 0) ? 1 : 0));

        // Reset while in service
        push_req(4, 500);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(posedge clk); #1;
            seen = (phase == 3);
        end
        check_val("reach_service", int'(seen), 1);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("rst_svc");
        @(posedge clk); #1;
        reset = 1'b0;

        // Reset in the done cycle
        push_req(7, 0);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(posedge clk); #1;
            seen = ifc.bus_oe;
        end
        check_val("reach_done", int'(seen), 1);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("rst_done");
        @(posedge clk); #1;
        reset = 1'b0;

`ifdef INTR_RESP_TIMEOUT_EN
        // Controller never supplies an ID
        mute = 1'b1;
        push_req(0, 0);
        for (int i = 0; i < 50 && tout_cnt == 0; i++) begin
            @(posedge clk); #1;
        end
        check_val("timeout_seen", tout_cnt, 1);
        mute = 1'b0;
        push_req(3, 1);
        wait_done(1);
        check_val("err_sticky", int'(ifc.intr_err), 1);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_val("err_cleared", int'(ifc.intr_err), 0);
        @(posedge clk); #1;
        reset = 1'b0;
`else
        push_req(6, 3);
        wait_done(1);
        check_val("err_tied_low", int'(ifc.intr_err), 0);
`endif

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/interrupt_responder.md
# interrupt_responder

- CPU-side end of the interrupt handshake; it answers the interrupt controller's request line and talks to it over the shared 8-bit interrupt bus.
- Handshake sequence:
  - acknowledge the request with a one-cycle low pulse on the ack line;
  - capture the source ID the controller places on the bus;
  - pulse the ack line again to release the bus;
  - hand the ID to the CPU;
  - after the CPU reports service complete, drive the done code with the ID back onto the bus.
- Sits between the interrupt controller and the CPU core.

## Interface
Parameters:
- ID_TIMEOUT, 16: cycles to wait in S_WaitId for a valid ID code before flagging an error (timeout build only).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- intr  in  1  interrupt request from the controller.
- intr_ack_n  out  1  ack to the controller, active low; idle high.
- intr_bus  inout  8  shared bidirectional interrupt bus.
- bus_oe  out  1  high while this block drives intr_bus.
- intr_enable  in  1  CPU global interrupt enable.
- isr_start  out  1  one-cycle pulse: ISR must start for isr_id.
- isr_id  out  3  captured source ID; held until the next capture.
- isr_done  in  1  CPU reports the ISR is finished.
- busy  out  1  high in any state other than S_Idle.
- intr_err  out  1  sticky ID-timeout flag.

## Operation
Bus codes:
- ID code, controller to CPU: intr_bus[7:3] = 5'b01011, bits [2:0] = ID.
- Done code, CPU to controller: intr_bus[7:3] = 5'b10100, bits [2:0] = ID.

When bus_oe is low, intr_bus is high-Z. When bus_oe is high, it carries the registered data.

FSM states:
- S_Idle:
  - intr_ack_n = 1, bus_oe = 0.
  - If intr and intr_enable, go to S_Ack1.
  - If intr_enable = 0, the request stays pending and is not acknowledged.
- S_Ack1:
  - intr_ack_n = 0 for exactly one cycle; then S_WaitId.
- S_WaitId:
  - intr_ack_n = 1.
  - If intr_bus[7:3] == 01011: latch intr_bus[2:0] into isr_id, go to S_Ack2.
  - Otherwise stay; watchdog counting (timeout build only).
- S_Ack2:
  - intr_ack_n = 0 for exactly one cycle.
  - The controller releases the bus on the following edge.
  - Then go to S_Service.
- S_Service:
  - isr_start = 1 on the first cycle only.
  - Wait for isr_done; isr_done is honoured on any cycle in this state, including the first.
  - On isr_done, go to S_Turn.
- S_Turn:
  - One bus turnaround cycle with bus_oe = 0; then S_Done.
- S_Done, one cycle:
  - bus_oe = 1, intr_bus = {10100, isr_id}, intr_ack_n = 0.
  - Then S_Idle; bus released on the next edge.

Rules:
- intr_ack_n is never low for two consecutive cycles.
- isr_done outside S_Service is ignored.
- intr falling mid-handshake is ignored; the handshake completes.

## Timing
- Reset values:
  - intr_ack_n = 1, bus_oe = 0, isr_start = 0, isr_id = 0, busy = 0, intr_err = 0.
  - State S_Idle, watchdog cleared.
- Reset asserted in any state takes effect at the next edge. The block immediately stops driving the bus and drops ack.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Latency:
  - intr sampled high at edge E0, so intr_ack_n is low in cycle E0..E1.
  - Controller ID is valid from E1; it is captured at E2.
  - Second ack is in E2..E3.
  - isr_start is in E3..E4.
  - The done code goes out 2 cycles after isr_done is sampled.
- Minimum full transaction with isr_done already high: 7 cycles from intr to S_Idle.
- Back-to-back: a new intr is accepted on the first S_Idle cycle.

## Configuration
INTR_RESP_TIMEOUT_EN:
- Defined:
  - intr_watchdog counts cycles in S_WaitId.
  - Reaching ID_TIMEOUT sets intr_err (sticky until reset) and returns to S_Idle with intr_ack_n = 1.
- Undefined:
  - No counter; S_WaitId waits indefinitely.
  - intr_err tied to 0 and ID_TIMEOUT unused.

## Structure
- Shared package intr_pkg, reused by the controller:
  - INTR_CODE_ID = 5'b01011
  - INTR_CODE_DONE = 5'b10100
  - responder state encoding localparams
- Sub-module intr_watchdog:
  - Down-counter with clear, enable and expired output.
  - Instantiated only under INTR_RESP_TIMEOUT_EN.

## Test plan
Each scenario runs against the interrupt controller model.
- Source 5 requested, intr_enable = 1, isr_done held high:
  - isr_id = 5, isr_start is a single pulse at E3.
  - Done bus value 8'hA5 with intr_ack_n = 0 for one cycle.
  - Controller returns to polling.
- Source 2, isr_done delayed 20 cycles:
  - busy stays high throughout; intr_ack_n is high the whole service time.
  - Done value 8'hA2 appears 2 cycles after isr_done.
- intr_enable = 0 with intr high for 30 cycles, then 1:
  - No ack during the 30 cycles.
  - Ack starts the cycle after enable rises; ID captured correctly.
- Timeout build, ID_TIMEOUT = 4, bus held high-Z after ack:
  - intr_err = 1 after 4 cycles in S_WaitId, block back in S_Idle, bus_oe = 0.
- Reset asserted in S_Service and again in S_Done:
  - Next edge: intr_ack_n = 1, bus_oe = 0, isr_id = 0, busy = 0.
- Sources 1 and 6 back-to-back:
  - Both serviced in order.
  - Checker confirms bus_oe of controller and responder never overlap, and ack is never low 2 cycles in a row.
